// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 8-bit combinational ALU: queues opcode/operand commands,
// feeds the ALU from an accumulator and returns each result over a valid/ready port.
module alu_cmd_sequencer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_operand,
    input  logic              clr_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_ovf,
    output logic [DATA_W-1:0] acc,
    output logic              busy
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];
    localparam logic [2:0]  OP_ADD  = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESULT
    } state_t;

    state_t            state;
    logic [2:0]        fifo_op      [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_operand [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              ready_q;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign fifo_empty = (count == '0);
    assign push       = cmd_valid && ready_q;
    // Head is consumed only when the FSM moves into ISSUE.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == RESULT) && res_ready));
    assign count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    assign cmd_ready  = ready_q;
    assign res_valid  = (state == RESULT);
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]      <= cmd_op;
            fifo_operand[wr_ptr] <= cmd_operand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_q  <= 1'b0;
            acc      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != FULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                alu_a   <= acc;
                alu_b   <= fifo_operand[rd_ptr];
                alu_sel <= fifo_op[rd_ptr];
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    res_data <= alu_out;
                    acc      <= alu_out;
                    // ALU ovf is stale for every op except add.
                    res_ovf  <= (alu_sel == OP_ADD) && alu_ovf;
                    state    <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        state <= pop ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (clr_acc) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: table vectors, multi-cycle corner cases,
// and randomized traffic against a queue-based result model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_DEC  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_operand = '0;
    logic       clr_acc = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_ovf;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_ovf;
    logic [7:0] acc;
    logic       busy;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_rcv = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  model_acc = '0;
    logic        mon_en = 1'b0;
    logic        rr_en = 1'b0;
    logic        junk_rand = 1'b0;
    logic        junk_ovf = 1'b1;
    logic [8:0]  add9;
    logic [8:0]  mon_exp;

    typedef struct {
        logic [2:0] op;
        logic [7:0] operand;
        logic [7:0] exp_res;
        logic       exp_ovf;
    } vec_t;
    vec_t vecs [9];

    alu_cmd_sequencer #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .clr_acc(clr_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
        .acc(acc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational ALU; ovf is deliberately junk outside add.
    always_comb begin
        add9    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = '0;
        alu_ovf = junk_ovf;
        case (alu_sel)
            3'd0: alu_out = alu_a;
            3'd1: alu_out = alu_a + 8'd1;
            3'd2: alu_out = alu_a - 8'd1;
            3'd3: alu_out = {7'b0, ~|alu_a};
            3'd4: begin alu_out = add9[7:0]; alu_ovf = add9[8]; end
            3'd5: alu_out = alu_a - alu_b;
            3'd6: alu_out = alu_a * alu_b;
            default: alu_out = alu_a | alu_b;
        endcase
    end

    // Reference result {ovf, value} from integer arithmetic, wrapped to a byte.
    function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        int unsigned r  = 0;
        logic ovf;
        case (op)
            OP_PASS: r = ai;
            OP_INC:  r = ai + 1;
            OP_DEC:  r = ai + 255;
            OP_NOT:  r = (ai == 0) ? 1 : 0;
            OP_ADD:  r = ai + bi;
            OP_SUB:  r = ai + 256 - bi;
            OP_MUL:  r = ai * bi;
            default: r = ai | bi;
        endcase
        ovf = (op == OP_ADD) && (r > 255);
        return {ovf, r[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] operand);
        int unsigned n = 0;
        logic [8:0] r;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_operand = operand;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) check("cmd_ready_timeout", cmd_ready, 1);
        @(posedge clk);
        r = ref_op(op, model_acc, operand);
        exp_q.push_back(r);
        model_acc = r[7:0];
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int unsigned budget, output int unsigned cycles);
        cycles = 0;
        while (!res_valid && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume_one();
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic apply_vec(input int unsigned i);
        int unsigned cyc;
        push_cmd(vecs[i].op, vecs[i].operand);
        exp_q.delete();
        wait_valid(20, cyc);
        check($sformatf("v%0d_latency", i), cyc, 4);
        check($sformatf("v%0d_res_data", i), res_data, vecs[i].exp_res);
        check($sformatf("v%0d_res_ovf", i), res_ovf, vecs[i].exp_ovf);
        check($sformatf("v%0d_acc", i), acc, vecs[i].exp_res);
        consume_one();
        @(negedge clk);
        check($sformatf("v%0d_valid_drop", i), res_valid, 0);
    endtask

    task automatic drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (junk_rand) junk_ovf = 1'($urandom_range(0, 1));
        if (mon_en && rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", res_valid, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("mon_res_data", res_data, mon_exp[7:0]);
                check("mon_res_ovf", res_ovf, mon_exp[8]);
                n_rcv++;
            end
        end
    end

    always @(posedge clk) begin
        if (rr_en) begin
            #1 res_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        int unsigned rcv0;
        vecs[0] = '{OP_ADD, 8'h05, 8'h05, 1'b0};
        vecs[1] = '{OP_ADD, 8'hFF, 8'h04, 1'b1};
        vecs[2] = '{OP_SUB, 8'h05, 8'hFF, 1'b0};
        vecs[3] = '{OP_ADD, 8'h05, 8'h04, 1'b1};
        vecs[4] = '{OP_NOT, 8'h00, 8'h01, 1'b0};
        vecs[5] = '{OP_DEC, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{OP_DEC, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{OP_INC, 8'h00, 8'h00, 1'b0};
        vecs[8] = '{OP_ADD, 8'h10, 8'h10, 1'b0};

        // Reset state
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_acc", acc, 0);
        check("rst_alu_regs", {alu_a, alu_b, 5'b0, alu_sel}, 0);
        check("rst_res", {res_data, 7'b0, res_ovf}, 0);
        #10 rst_n = 1'b1;
        #1 check("ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1);
        @(posedge clk); #1 clr_acc = 1'b1;
        @(posedge clk); #1 clr_acc = 1'b0;
        model_acc = '0;

        // Basic ops, wrap and stale-ovf cases
        for (int unsigned i = 0; i < 4; i++) apply_vec(i);

        // Burst of six with the result port stalled
        mon_en = 1'b1;
        rcv0 = n_rcv;
        push_cmd(OP_MUL, 8'h03);
        push_cmd(OP_OR,  8'hF0);
        push_cmd(OP_INC, 8'h00);
        push_cmd(OP_DEC, 8'h00);
        push_cmd(OP_NOT, 8'h00);
        @(negedge clk);
        check("burst_full_ready", cmd_ready, 0);
        check("burst_busy", busy, 1);
        fork
            push_cmd(OP_PASS, 8'h00);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("stall_valid", res_valid, 1);
                    check("stall_data", res_data, 8'h0C);
                    check("stall_ready", cmd_ready, 0);
                end
                @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        drain("burst_drain", 100);
        check("burst_count", n_rcv - rcv0, 6);
        @(posedge clk); #1 res_ready = 1'b0;
        mon_en = 1'b0;
        check("burst_acc", acc, 8'h00);

        // NOT/INC/DEC boundaries, ending with acc = 0x10
        for (int unsigned i = 4; i < 9; i++) apply_vec(i);

        // clr_acc coincident with the CAPTURE edge
        push_cmd(OP_ADD, 8'h07);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1 clr_acc = 1'b1;
        @(posedge clk); #1 clr_acc = 1'b0;
        @(negedge clk);
        check("clr_cap_valid", res_valid, 1);
        check("clr_cap_res", res_data, 8'h17);
        check("clr_cap_acc", acc, 8'h00);
        consume_one();

        // clr_acc during ISSUE leaves alu_a with the old accumulator
        model_acc = 8'h00;
        push_cmd(OP_ADD, 8'h05);
        exp_q.delete();
        wait_valid(20, cyc);
        consume_one();
        push_cmd(OP_ADD, 8'h02);
        exp_q.delete();
        @(posedge clk); #1 clr_acc = 1'b1;
        @(negedge clk);
        check("clr_issue_alu_a", alu_a, 8'h05);
        @(posedge clk); #1 clr_acc = 1'b0;
        @(negedge clk);
        check("clr_issue_acc", acc, 8'h00);
        check("clr_issue_alu_a_hold", alu_a, 8'h05);
        wait_valid(20, cyc);
        check("clr_issue_res", res_data, 8'h07);
        check("clr_issue_acc_after", acc, 8'h07);
        consume_one();
        model_acc = 8'h07;

        // Randomized traffic with random back-pressure and junk ALU ovf
        mon_en = 1'b1;
        junk_rand = 1'b1;
        rcv0 = n_rcv;
        @(negedge clk);
        rr_en = 1'b1;
        for (int unsigned k = 0; k < 40; k++) begin
            push_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("rand_drain", 400);
        check("rand_count", n_rcv - rcv0, 40);
        @(negedge clk);
        rr_en = 1'b0;
        @(posedge clk); #1 res_ready = 1'b0;
        mon_en = 1'b0;
        junk_rand = 1'b0;
        junk_ovf = 1'b1;
        @(negedge clk);
        check("rand_acc", acc, model_acc);

        // Async reset while in RESULT with two commands queued
        push_cmd(OP_ADD, 8'h01);
        push_cmd(OP_ADD, 8'h01);
        push_cmd(OP_ADD, 8'h01);
        wait_valid(30, cyc);
        check("pre_rst_valid", res_valid, 1);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", res_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_acc", acc, 0);
        check("async_rst_ready", cmd_ready, 0);
        exp_q.delete();
        model_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_quiet", {res_valid, busy}, 0);
        end
        push_cmd(OP_ADD, 8'h09);
        exp_q.delete();
        wait_valid(20, cyc);
        check("post_rst_latency", cyc, 4);
        check("post_rst_res", res_data, 8'h09);
        consume_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
